pwm_multi: RTL and testbench

Parametrised multi-channel pulse-width modulator for the Minisys-1A I/O bus. It provides CHANNELS independent PWM outputs, each with its own period (maximum), threshold, control and status registers. Shadow registers make duty and period updates glitch-free, and a shared interrupt line signals period completion. The block sits on the memory-mapped peripheral bus behind the PWM chip-select and replaces the single-channel PWM at 0xFFFFFC30.

---
 rtl/pwm_multi.sv | 197 +++++++++++++++++++
 tb/tb_pwm_multi.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral for the Minisys-1A memory-mapped I/O bus.
// Each channel has max/thr/ctrl/status registers and a free-running counter.
// Optional feature macro: PWM_SHADOW_EN. When defined, max/thr are double-buffered
// (bus writes land in shadow registers, copied to the active pair on wrap or while
// disabled). When undefined, writes go straight to the active registers.
module pwm_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned AW       = 3 + $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pwmCtrl,
  input  logic                write_enable,
  input  logic [AW-1:0]       address,
  input  logic [WIDTH-1:0]    write_data_in,
  output logic [WIDTH-1:0]    read_data_out,
  output logic [CHANNELS-1:0] PWM_output,
  output logic                irq
);

  localparam logic [WIDTH-1:0] MaxRst = '1;
  localparam logic [WIDTH-1:0] ThrRst = MaxRst >> 1;

  localparam logic [1:0] RegMax    = 2'd0;
  localparam logic [1:0] RegThr    = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  logic [WIDTH-1:0]    act_max_q [CHANNELS];
  logic [WIDTH-1:0]    act_max_d [CHANNELS];
  logic [WIDTH-1:0]    act_thr_q [CHANNELS];
  logic [WIDTH-1:0]    act_thr_d [CHANNELS];
  logic [WIDTH-1:0]    cnt_q     [CHANNELS];
  logic [WIDTH-1:0]    cnt_d     [CHANNELS];
  logic [2:0]          ctrl_q    [CHANNELS];
  logic [2:0]          ctrl_d    [CHANNELS];
  logic [WIDTH-1:0]    vis_max   [CHANNELS];
  logic [WIDTH-1:0]    vis_thr   [CHANNELS];
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                irq_q, irq_d;
`ifdef PWM_SHADOW_EN
  logic [WIDTH-1:0]    shd_max_q [CHANNELS];
  logic [WIDTH-1:0]    shd_max_d [CHANNELS];
  logic [WIDTH-1:0]    shd_thr_q [CHANNELS];
  logic [WIDTH-1:0]    shd_thr_d [CHANNELS];
`endif

  logic [AW-1:0]       ch_field;
  logic [CHANNELS-1:0] ch_hit;
  logic [1:0]          reg_sel;
  logic                wr;

  assign ch_field   = address >> 3;
  assign wr         = pwmCtrl & write_enable;
  assign PWM_output = pwm_q;
  assign irq        = irq_q;

  // Address decode: channel hit vector and register select (odd offsets alias down).
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_hit[i] = (ch_field == AW'(i));
    end
    unique case (address[2:0])
      3'd0, 3'd1: reg_sel = RegMax;
      3'd2, 3'd3: reg_sel = RegThr;
      3'd4, 3'd5: reg_sel = RegCtrl;
      default:    reg_sel = RegStatus;
    endcase
  end

  // Bus-visible max/thr: shadow copies when double-buffered, else the active pair.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_SHADOW_EN
      vis_max[i] = shd_max_q[i];
      vis_thr[i] = shd_thr_q[i];
`else
      vis_max[i] = act_max_q[i];
      vis_thr[i] = act_thr_q[i];
`endif
    end
  end

  // Per-channel next state: counter, reloads, bus writes, DONE, output level and irq.
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      logic wrap;
      ctrl_d[i]    = ctrl_q[i];
      done_d[i]    = done_q[i];
      cnt_d[i]     = cnt_q[i];
      act_max_d[i] = act_max_q[i];
      act_thr_d[i] = act_thr_q[i];
`ifdef PWM_SHADOW_EN
      shd_max_d[i] = shd_max_q[i];
      shd_thr_d[i] = shd_thr_q[i];
`endif
      wrap = ctrl_q[i][0] && (cnt_q[i] >= act_max_q[i]);

      if (!ctrl_q[i][0]) begin
        cnt_d[i] = '0;
`ifdef PWM_SHADOW_EN
        act_max_d[i] = shd_max_q[i];
        act_thr_d[i] = shd_thr_q[i];
`endif
      end else if (wrap) begin
        cnt_d[i] = '0;
`ifdef PWM_SHADOW_EN
        act_max_d[i] = shd_max_q[i];
        act_thr_d[i] = shd_thr_q[i];
`endif
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      if (wr && ch_hit[i]) begin
        unique case (reg_sel)
          RegMax: begin
`ifdef PWM_SHADOW_EN
            shd_max_d[i] = write_data_in;
`else
            act_max_d[i] = write_data_in;
`endif
          end
          RegThr: begin
`ifdef PWM_SHADOW_EN
            shd_thr_d[i] = write_data_in;
`else
            act_thr_d[i] = write_data_in;
`endif
          end
          RegCtrl:   ctrl_d[i] = write_data_in[2:0];
          default: begin
            if (write_data_in[0]) done_d[i] = 1'b0;
          end
        endcase
      end

      // A wrap in the same cycle as a W1C keeps DONE set.
      if (wrap) done_d[i] = 1'b1;

      pwm_d[i] = ctrl_q[i][0] ? ((cnt_q[i] < act_thr_q[i]) ^ ctrl_q[i][1]) : ctrl_q[i][1];
      irq_d    = irq_d | (done_q[i] & ctrl_q[i][2]);
    end
  end

  // Combinational read mux; zero when not selected or channel out of range.
  always_comb begin
    read_data_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pwmCtrl && ch_hit[i]) begin
        unique case (reg_sel)
          RegMax:  read_data_out = vis_max[i];
          RegThr:  read_data_out = vis_thr[i];
          RegCtrl: read_data_out = WIDTH'(ctrl_q[i]);
          default: read_data_out = WIDTH'({pwm_q[i], done_q[i]});
        endcase
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        act_max_q[i] <= MaxRst;
        act_thr_q[i] <= ThrRst;
        cnt_q[i]     <= '0;
        ctrl_q[i]    <= '0;
`ifdef PWM_SHADOW_EN
        shd_max_q[i] <= MaxRst;
        shd_thr_q[i] <= ThrRst;
`endif
      end
      done_q <= '0;
      pwm_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        act_max_q[i] <= act_max_d[i];
        act_thr_q[i] <= act_thr_d[i];
        cnt_q[i]     <= cnt_d[i];
        ctrl_q[i]    <= ctrl_d[i];
`ifdef PWM_SHADOW_EN
        shd_max_q[i] <= shd_max_d[i];
        shd_thr_q[i] <= shd_thr_d[i];
`endif
      end
      done_q <= done_d;
      pwm_q  <= pwm_d;
      irq_q  <= irq_d;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi. Expected waveforms come from the closed-form
// rule: k edges after the enable edge the output is (((k-1) mod (max+1)) < thr) ^ inv.
module tb_pwm_multi;

  logic        clock;
  logic        reset;
  logic        pwm_ctrl;
  logic        write_enable;
  logic [4:0]  address;
  logic [15:0] write_data_in;
  logic [15:0] read_data_out;
  logic [3:0]  pwm_out;
  logic        irq;

  // Second instance with 3 channels so an out-of-range channel index is addressable.
  logic        s_ctrl;
  logic        s_we;
  logic [4:0]  s_addr;
  logic [15:0] s_wdata;
  logic [15:0] s_rdata;
  logic [2:0]  s_pwm;
  logic        s_irq;

  int checks = 0;
  int errors = 0;

  pwm_multi #(.CHANNELS(4), .WIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .pwmCtrl       (pwm_ctrl),
    .write_enable  (write_enable),
    .address       (address),
    .write_data_in (write_data_in),
    .read_data_out (read_data_out),
    .PWM_output    (pwm_out),
    .irq           (irq)
  );

  pwm_multi #(.CHANNELS(3), .WIDTH(16)) dut_small (
    .clock         (clock),
    .reset         (reset),
    .pwmCtrl       (s_ctrl),
    .write_enable  (s_we),
    .address       (s_addr),
    .write_data_in (s_wdata),
    .read_data_out (s_rdata),
    .PWM_output    (s_pwm),
    .irq           (s_irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic exp_level(input int k, input int mx, input int thr, input logic inv);
    return ((((k - 1) % (mx + 1)) < thr) ? 1'b1 : 1'b0) ^ inv;
  endfunction

  // Called during the low clock phase; the write lands on the next rising edge.
  task automatic bus_write(input int ch, input int off, input int data);
    pwm_ctrl      = 1'b1;
    write_enable  = 1'b1;
    address       = 5'(ch * 8 + off);
    write_data_in = 16'(data);
    @(negedge clock);
    pwm_ctrl      = 1'b0;
    write_enable  = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int off, output logic [15:0] data);
    pwm_ctrl     = 1'b1;
    write_enable = 1'b0;
    address      = 5'(ch * 8 + off);
    #1;
    data     = read_data_out;
    pwm_ctrl = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] r;
    @(negedge clock);
    checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL rst_pwm: got %h expected 0", pwm_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    checks++; if (read_data_out !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", read_data_out); end
    reset = 1'b0;
    bus_read(0, 0, r);
    checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL rst_max: got %h expected ffff", r); end
    bus_read(0, 2, r);
    checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL rst_thr: got %h expected 7fff", r); end
    bus_read(0, 3, r);
    checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL rst_thr_alias: got %h expected 7fff", r); end
    @(negedge clock);
    bus_read(0, 4, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL rst_ctrl: got %h expected 0", r); end
    bus_read(0, 6, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", r); end
    @(negedge clock);
  endtask

  task automatic test_basic;
    logic [15:0] r;
    bus_write(0, 0, 3);
    bus_write(0, 2, 1);
    bus_write(0, 4, 1);
    checks++; if (pwm_out[0] !== 1'b0) begin errors++; $display("FAIL basic_pre: got %b expected 0", pwm_out[0]); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      checks++;
      if (pwm_out[0] !== exp_level(k, 3, 1, 1'b0)) begin
        errors++; $display("FAIL basic_wave k=%0d: got %b expected %b", k, pwm_out[0], exp_level(k, 3, 1, 1'b0));
      end
      bus_read(0, 6, r);
      checks++;
      if (r[0] !== (k >= 4)) begin
        errors++; $display("FAIL basic_done k=%0d: got %b expected %b", k, r[0], (k >= 4));
      end
    end
    bus_write(0, 4, 0);
    bus_write(0, 6, 1);
    checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL basic_off: got %h expected 0", pwm_out); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int ch, mx, thr, n;
      logic inv;
      logic [3:0] e;
      ch  = int'($urandom_range(0, 3));
      mx  = int'($urandom_range(0, 7));
      thr = int'($urandom_range(0, 9));
      inv = 1'($urandom_range(0, 1));
      n   = 2 * (mx + 1) + 3;
      bus_write(ch, 0, mx);
      bus_write(ch, 2, thr);
      bus_write(ch, 4, (inv ? 2 : 0) + 1);
      for (int k = 1; k <= n; k++) begin
        @(negedge clock);
        e = 4'h0;
        e[ch] = exp_level(k, mx, thr, inv);
        checks++;
        if (pwm_out !== e) begin
          errors++;
          $display("FAIL rand ch=%0d max=%0d thr=%0d inv=%b k=%0d: got %h expected %h",
                   ch, mx, thr, inv, k, pwm_out, e);
        end
      end
      bus_write(ch, 4, 0);
      bus_write(ch, 6, 1);
      checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL rand_off ch=%0d: got %h expected 0", ch, pwm_out); end
    end
  endtask

  task automatic test_shadow;
    logic [15:0] r;
    logic e;
    bus_write(1, 0, 3);
    bus_write(1, 2, 2);
    bus_write(1, 4, 1);
    bus_write(1, 2, 0);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clock);
`ifdef PWM_SHADOW_EN
      e = (k <= 2);
`else
      e = (k == 1);
`endif
      checks++;
      if (pwm_out[1] !== e) begin
        errors++; $display("FAIL shadow_wave k=%0d: got %b expected %b", k, pwm_out[1], e);
      end
    end
    bus_read(1, 2, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL shadow_thr_read: got %h expected 0", r); end
    bus_write(1, 4, 0);
    bus_write(1, 6, 1);
  endtask

  task automatic test_irq;
    logic [15:0] r;
    bus_write(2, 0, 1);
    bus_write(2, 2, 1);
    bus_write(2, 4, 7);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      checks++;
      if (pwm_out[2] !== exp_level(k, 1, 1, 1'b1)) begin
        errors++; $display("FAIL irq_wave k=%0d: got %b expected %b", k, pwm_out[2], exp_level(k, 1, 1, 1'b1));
      end
      checks++;
      if (irq !== (k >= 3)) begin
        errors++; $display("FAIL irq_level k=%0d: got %b expected %b", k, irq, (k >= 3));
      end
    end
    // Edge 8 is a wrap: the clear and the set coincide.
    bus_write(2, 6, 1);
    bus_read(2, 6, r);
    checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL irq_w1c_wrap: got %b expected 1", r[0]); end
    bus_write(2, 6, 1);
    bus_read(2, 6, r);
    checks++; if (r[0] !== 1'b0) begin errors++; $display("FAIL irq_w1c_clear: got %b expected 0", r[0]); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_still_high: got %b expected 1", irq); end
    @(negedge clock);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", irq); end
    bus_write(2, 4, 0);
    bus_write(2, 6, 1);
  endtask

  task automatic test_multi;
    logic [3:0] e;
    bus_write(0, 0, 2);
    bus_write(0, 2, 1);
    bus_write(3, 0, 5);
    bus_write(3, 2, 3);
    bus_write(0, 4, 1);
    bus_write(3, 4, 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      e = 4'h0;
      e[0] = exp_level(k + 1, 2, 1, 1'b0);
      e[3] = exp_level(k, 5, 3, 1'b0);
      checks++;
      if (pwm_out !== e) begin
        errors++; $display("FAIL multi k=%0d: got %h expected %h", k, pwm_out, e);
      end
    end
    bus_write(0, 4, 0);
    bus_write(3, 4, 0);
    @(negedge clock);
    checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL multi_off: got %h expected 0", pwm_out); end
  endtask

  task automatic test_oob;
    s_ctrl  = 1'b1;
    s_we    = 1'b1;
    s_addr  = 5'd24;
    s_wdata = 16'h1234;
    @(negedge clock);
    s_addr  = 5'd28;
    s_wdata = 16'h0001;
    @(negedge clock);
    s_we   = 1'b0;
    s_addr = 5'd24;
    #1;
    checks++; if (s_rdata !== 16'h0) begin errors++; $display("FAIL oob_max: got %h expected 0", s_rdata); end
    s_addr = 5'd28;
    #1;
    checks++; if (s_rdata !== 16'h0) begin errors++; $display("FAIL oob_ctrl: got %h expected 0", s_rdata); end
    s_addr = 5'd0;
    #1;
    checks++; if (s_rdata !== 16'hFFFF) begin errors++; $display("FAIL oob_ch0_max: got %h expected ffff", s_rdata); end
    s_ctrl = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (s_pwm !== 3'h0) begin errors++; $display("FAIL oob_pwm k=%0d: got %h expected 0", k, s_pwm); end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] r;
    bus_write(0, 0, 3);
    bus_write(0, 2, 2);
    bus_write(0, 4, 1);
    @(negedge clock);
    checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b expected 1", pwm_out[0]); end
    reset = 1'b1;
    #1;
    checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL rmid_pwm: got %h expected 0", pwm_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_irq: got %b expected 0", irq); end
    bus_read(0, 4, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL rmid_ctrl: got %h expected 0", r); end
    bus_read(0, 0, r);
    checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL rmid_max: got %h expected ffff", r); end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checks++;
      if (pwm_out !== 4'h0) begin errors++; $display("FAIL rmid_idle k=%0d: got %h expected 0", k, pwm_out); end
    end
  endtask

  initial begin
    reset         = 1'b1;
    pwm_ctrl      = 1'b0;
    write_enable  = 1'b0;
    address       = '0;
    write_data_in = '0;
    s_ctrl        = 1'b0;
    s_we          = 1'b0;
    s_addr        = '0;
    s_wdata       = '0;
    test_reset;
    test_basic;
    test_random;
    test_shadow;
    test_irq;
    test_multi;
    test_oob;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
